// File: rtl/conv_stream_sender.sv
// rtl/conv_stream_sender.sv - host-side IFM/weight streamer and OFM result collector for the conv engine
module conv_stream_sender #(
  parameter int IFM_N = 49,
  parameter int W_N   = 9,
  parameter int OFM_N = 25,
  parameter int DW    = 16,
  parameter int OW    = 36
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [5:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  output logic          busy,
  output logic          in_valid,
  output logic [DW-1:0] In_IFM_1,
  output logic          weight_valid,
  output logic [DW-1:0] In_Weight_1,
  input  logic          ofm_valid,
  input  logic [OW-1:0] ofm_data,
  output logic          done,
  output logic [OW+4:0] ofm_sum,
  output logic [OW-1:0] ofm_max,
  output logic [4:0]    ofm_max_idx
);

  localparam logic [5:0] S_LAST = 6'(IFM_N - 1);
  localparam logic [5:0] W_LIM  = 6'(W_N);
  localparam logic [5:0] A_W0   = 6'(IFM_N);
  localparam logic [5:0] A_END  = 6'(IFM_N + W_N);
  localparam logic [4:0] R_LAST = 5'(OFM_N - 1);
  localparam logic [4:0] R_FULL = 5'(OFM_N);

  typedef enum logic [1:0] {IDLE, SEND, COLLECT, DONE} state_t;

  state_t        state, state_n;
  logic [DW-1:0] ifm_buf [IFM_N];
  logic [DW-1:0] w_buf [W_N];
  logic [5:0]    scnt;
  logic [4:0]    rcnt;
  logic          accept;
  logic          send_go;
  logic [5:0]    send_idx;
  logic          wr_ok;
  logic          send_w;
  logic [3:0]    w_wr_idx;

  assign w_wr_idx = 4'(wr_addr - A_W0);
  assign send_w   = send_go && (send_idx < W_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // send_go/send_idx describe the word that will be on the stream next cycle
  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    send_go  = 1'b0;
    send_idx = '0;
    wr_ok    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SEND;
          send_go = 1'b1;
        end else begin
          wr_ok = wr_en && (wr_addr < A_END);
        end
      end
      SEND: begin
        accept = ofm_valid && (rcnt < R_FULL);
        if (scnt == S_LAST) begin
          state_n = ((rcnt == R_FULL) || (accept && rcnt == R_LAST)) ? DONE : COLLECT;
        end else begin
          send_go  = 1'b1;
          send_idx = scnt + 6'd1;
        end
      end
      COLLECT: begin
        accept = ofm_valid && (rcnt < R_FULL);
        if (accept && rcnt == R_LAST) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IFM_N; i++) ifm_buf[i] <= '0;
      for (int i = 0; i < W_N; i++)   w_buf[i]   <= '0;
    end else if (wr_ok) begin
      if (wr_addr < A_W0) ifm_buf[wr_addr]  <= wr_data;
      else                w_buf[w_wr_idx]   <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      in_valid     <= 1'b0;
      In_IFM_1     <= '0;
      weight_valid <= 1'b0;
      In_Weight_1  <= '0;
      scnt         <= '0;
      rcnt         <= '0;
      ofm_sum      <= '0;
      ofm_max      <= '0;
      ofm_max_idx  <= '0;
    end else begin
      busy         <= (state_n != IDLE);
      done         <= (state_n == DONE);
      in_valid     <= send_go;
      In_IFM_1     <= send_go ? ifm_buf[send_idx] : '0;
      weight_valid <= send_w;
      In_Weight_1  <= send_w ? w_buf[send_idx[3:0]] : '0;
      if (state == IDLE && start) begin
        scnt        <= '0;
        rcnt        <= '0;
        ofm_sum     <= '0;
        ofm_max     <= '0;
        ofm_max_idx <= '0;
      end else begin
        if (state == SEND && scnt != S_LAST) scnt <= scnt + 6'd1;
        if (accept) begin
          ofm_sum <= ofm_sum + {5'b0, ofm_data};
          // strict compare keeps the earliest index on ties
          if (rcnt == 5'd0 || ofm_data > ofm_max) begin
            ofm_max     <= ofm_data;
            ofm_max_idx <= rcnt;
          end
          rcnt <= rcnt + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_stream_sender.sv
// tb/tb_conv_stream_sender.sv - self-checking bench for conv_stream_sender
module tb_conv_stream_sender;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic        busy;
  logic        in_valid;
  logic [15:0] In_IFM_1;
  logic        weight_valid;
  logic [15:0] In_Weight_1;
  logic        ofm_valid;
  logic [35:0] ofm_data;
  logic        done;
  logic [40:0] ofm_sum;
  logic [35:0] ofm_max;
  logic [4:0]  ofm_max_idx;

  conv_stream_sender dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .in_valid(in_valid), .In_IFM_1(In_IFM_1),
    .weight_valid(weight_valid), .In_Weight_1(In_Weight_1), .ofm_valid(ofm_valid),
    .ofm_data(ofm_data), .done(done), .ofm_sum(ofm_sum), .ofm_max(ofm_max),
    .ofm_max_idx(ofm_max_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          mode;
    int          delay;
    int          extra;
    bit          poke;
    bit          samew;
    logic [40:0] esum;
    logic [35:0] emax;
    logic [4:0]  eidx;
  } vec_t;

  typedef struct {
    logic [15:0] ifm;
    logic [15:0] w;
  } sword_t;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] ifm_m [49];
  logic [15:0] w_m [9];
  sword_t      exp_q [$];
  vec_t        tab [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] word(input int mode, input int i);
    if (i >= 25) return 36'd99;
    case (mode)
      0:       return 36'((i + 1) * 10);
      1:       return 36'd7;
      2:       return (i == 12) ? 36'hF_FFFF_FFFF : 36'd5;
      default: return 36'hF_FFFF_FFFF;
    endcase
  endfunction

  task automatic push_stream();
    sword_t e;
    for (int k = 0; k < 49; k++) begin
      e.ifm = ifm_m[k];
      e.w   = (k < 9) ? w_m[k] : 16'd0;
      exp_q.push_back(e);
    end
  endtask

  // stream scoreboard: every valid IFM beat must match the next queued word
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_extra: got word %0h expected no word", In_IFM_1);
        end else begin
          sword_t e;
          e = exp_q.pop_front();
          chk("ifm_data", In_IFM_1, e.ifm);
          chk("w_data", In_Weight_1, e.w);
        end
      end else begin
        chk("idle_data", {weight_valid, In_IFM_1, In_Weight_1}, 0);
      end
    end
  end

  task automatic host_write(input logic [5:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (a < 6'd49)      ifm_m[a] = d;
    else if (a < 6'd58) w_m[a - 6'd49] = d;
  endtask

  task automatic run_frame(input vec_t v);
    int jc, exp_done, done_cyc, done_cnt, fed, nw;
    push_stream();
    @(posedge clk); #1;
    start = 1'b1;
    if (v.samew) begin
      wr_en = 1'b1; wr_addr = 6'd1; wr_data = 16'hBEEF;
    end
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    jc = v.delay + 25;
    exp_done = (jc + 1 > 50) ? jc + 1 : 50;
    nw = 25 + v.extra;
    fed = 0; done_cyc = 0; done_cnt = 0;
    for (int j = 1; j <= exp_done + 3; j++) begin
      start = 1'b0; wr_en = 1'b0;
      if (v.poke && j == 10) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 6'd0; wr_data = 16'hFFFF;
      end
      ofm_valid = (j - 1 >= v.delay) && (fed < nw);
      ofm_data  = ofm_valid ? word(v.mode, fed) : 36'd0;
      if (ofm_valid) fed++;
      @(negedge clk);
      if (j == 1 || j == 9 || j == 10 || j == 49 || j == 50) begin
        chk("in_valid", in_valid, j <= 49);
        chk("weight_valid", weight_valid, j <= 9);
      end
      if (j == 1 || j == exp_done || j == exp_done + 1) chk("busy", busy, j <= exp_done);
      if (done) begin
        done_cnt++;
        done_cyc = j;
      end
      @(posedge clk); #1;
    end
    ofm_valid = 1'b0; ofm_data = 36'd0; start = 1'b0; wr_en = 1'b0;
    chk("done_count", done_cnt, 1);
    chk("done_cycle", done_cyc, exp_done);
    chk("ofm_sum", ofm_sum, v.esum);
    chk("ofm_max", ofm_max, v.emax);
    chk("ofm_max_idx", ofm_max_idx, v.eidx);
    chk("stream_left", exp_q.size(), 0);
  endtask

  initial begin
    tab[0] = '{0, 60, 0, 1'b0, 1'b0, 41'd3250, 36'd250, 5'd24};
    tab[1] = '{0, 60, 0, 1'b0, 1'b0, 41'd3250, 36'd250, 5'd24};
    tab[2] = '{1, 28, 1, 1'b0, 1'b0, 41'd175, 36'd7, 5'd0};
    tab[3] = '{2, 10, 0, 1'b1, 1'b0, 41'd68719476855, 36'hF_FFFF_FFFF, 5'd12};
    tab[4] = '{3, 0, 1, 1'b0, 1'b1, 41'd1717986918375, 36'hF_FFFF_FFFF, 5'd0};
    tab[5] = '{0, 45, 0, 1'b0, 1'b0, 41'd3250, 36'd250, 5'd24};
    for (int k = 0; k < 49; k++) ifm_m[k] = 16'd0;
    for (int k = 0; k < 9; k++)  w_m[k] = 16'd0;

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 6'd0; wr_data = 16'd0;
    start = 1'b0; ofm_valid = 1'b0; ofm_data = 36'd0;
    #12;
    chk("rst_outputs", {busy, in_valid, In_IFM_1, weight_valid, In_Weight_1, done}, 0);
    chk("rst_sum", ofm_sum, 0);
    chk("rst_max", {ofm_max, ofm_max_idx}, 0);
    #10 rst_n = 1'b1;

    run_frame(tab[0]);

    for (int k = 0; k < 58; k++) host_write(6'(k), 16'(k % 49 + 1));
    host_write(6'd60, 16'h1234);

    for (int i = 1; i < 6; i++) run_frame(tab[i]);

    // asynchronous reset in the middle of a send
    push_stream();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 1; j < 21; j++) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_valid", in_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_send", {in_valid, busy, done, In_IFM_1}, 0);
    exp_q.delete();
    for (int k = 0; k < 49; k++) ifm_m[k] = 16'd0;
    for (int k = 0; k < 9; k++)  w_m[k] = 16'd0;
    @(negedge clk); #2;
    rst_n = 1'b1;
    run_frame(tab[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_stream_sender.md
# conv_stream_sender

Host-side transmitter/collector for the 7x7 IFM / 3x3 weight convolution engine. The host preloads 49 IFM words and 9 weight words into local buffers. On `start`, the block streams them serially on the engine's `in_valid`/`weight_valid` input protocol. It then collects the engine's 25-word OFM result stream and reports the sum, the maximum and the index of the maximum.

## Interface

**Parameters**
- `IFM_N`, 49: IFM words per frame.
- `W_N`, 9: weight words per frame.
- `OFM_N`, 25: result words expected per frame.
- `DW`, 16: IFM/weight word width.
- `OW`, 36: OFM word width.

**Ports**
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `wr_en`  in  1: host buffer write strobe.
- `wr_addr`  in  6: address 0..48 is IFM[0..48]; 49..57 is W[0..8]; 58..63 is ignored.
- `wr_data`  in  DW: host write data.
- `start`  in  1: frame start request, level-sampled.
- `busy`  out  1: high from start acceptance through the `done` cycle.
- `in_valid`  out  1: IFM word valid toward the engine.
- `In_IFM_1`  out  DW: IFM word.
- `weight_valid`  out  1: weight word valid toward the engine.
- `In_Weight_1`  out  DW: weight word.
- `ofm_valid`  in  1: engine result valid (engine `out_valid`).
- `ofm_data`  in  OW: engine result (engine `Out_OFM`).
- `done`  out  1: one-cycle frame-complete pulse.
- `ofm_sum`  out  OW+5: sum of the 25 collected results.
- `ofm_max`  out  OW: largest collected result, unsigned.
- `ofm_max_idx`  out  5: arrival index (0..24) of `ofm_max`.

All outputs are registered. Every output resets to 0. Both buffers reset to 0.

## Operation

**States**
- IDLE
  - `start`=1 → SEND. The cycle that accepts `start` also clears `ofm_sum`, `ofm_max`, `ofm_max_idx`, the send counter `scnt` and the result counter `rcnt`.
- SEND
  - Drives word `scnt` each cycle, `scnt` running 0..48.
  - `scnt`=48 → COLLECT if `rcnt`<25, else → DONE.
- COLLECT
  - Waits for results; the transition to DONE occurs on the cycle that accepts the 25th result.
- DONE
  - `done`=1 for one cycle → IDLE.

**Streaming**
- For `scnt` = k:
  - `in_valid`=1, `In_IFM_1`=IFM[k].
  - `weight_valid` = (k<9); `In_Weight_1` = W[k] when k<9, else 0.
- Outside SEND: `in_valid`=`weight_valid`=0 and both data outputs are 0.

**Collection**
- `ofm_valid` is accepted in SEND and COLLECT while `rcnt`<25. It is ignored in IDLE/DONE and once `rcnt`=25.
- Each accepted word:
  - `ofm_sum` += `ofm_data`, zero-extended. There is no overflow; the width is sized for 25×(2^36−1).
  - If `rcnt`=0, or `ofm_data` > `ofm_max` (strictly greater), load `ofm_max`=`ofm_data` and `ofm_max_idx`=`rcnt`. Ties keep the earliest index.
  - `rcnt`++.
- `ofm_sum`/`ofm_max`/`ofm_max_idx` hold from DONE until the next start acceptance.

**Host writes**
- Accepted only when state=IDLE and `start`=0. Ignored while `busy`, or in the same cycle as `start`.
- Buffers are frozen during a frame.

**Reset**
- Reset asserted mid-frame forces IDLE immediately (asynchronous).
- All outputs go to 0 and buffers clear to 0. There is no partial `done`.

## Timing

- `start` high at edge T in IDLE:
  - `busy`=1 from T+1.
  - `in_valid`=1 carrying IFM[0] and `weight_valid`=1 carrying W[0] at T+1.
- `in_valid` is high for exactly 49 consecutive cycles (T+1..T+49).
- `weight_valid` is high for 9 consecutive cycles (T+1..T+9).
- Let C be the edge accepting the 25th result.
  - If C ≥ T+49 (normal case), DONE is entered at C and `done`=1 in the following cycle (C+1).
  - If 25 results arrive before the send finishes, DONE is entered after the T+49 edge.
- `busy` falls the cycle after `done`.
- A `start` held high continuously launches the next frame on the first IDLE cycle after DONE.
- `ofm_valid` may begin during SEND; those words are counted.
- Back-to-back `ofm_valid` is supported at one word per cycle.

## Test plan

- **Reset:** assert `rst_n`=0 → every output is 0. A start issued with no writes streams 49 zeros on `In_IFM_1` with `in_valid` high, and `weight_valid` high for 9 cycles.
- **Basic frame:**
  - Stimulus: write IFM[k]=k+1 and W[k]=k+1; pulse `start`.
  - Stream check: `In_IFM_1` = 1..49 on 49 consecutive cycles; `In_Weight_1` = 1..9 with `weight_valid`, then 0.
  - Collection check: feed results 10,20,…,250 → `done` pulse, `ofm_sum`=3250, `ofm_max`=250, `ofm_max_idx`=24.
- **Ties and early results:**
  - Feed 25 words of 7, starting at SEND cycle 28, then a 26th word of 99.
  - Required: `ofm_sum`=175, `ofm_max`=7, `ofm_max_idx`=0; the 26th word is ignored.
- **Busy protection:**
  - During SEND, pulse `start` and write `wr_addr`=0 with value 0xFFFF.
  - Required: no restart. The next frame still sends IFM[0]=1.
- **Same-cycle write+start:** `wr_en` and `start` high together in IDLE → start is accepted and the write is dropped.
- **Reset mid-SEND:** at `scnt`=20, assert `rst_n` → `in_valid`/`busy` go to 0 immediately. After release, a new start streams all zeros and `done` appears only after 25 new results.
